// File: rtl/alarm_pkg.sv
// Shared types and BCD constants for the alarm match/strobe generator.
package alarm_pkg;

    // Edit-mode state, cycled by rising edges of the set button
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2
    } state_t;

    // Largest legal BCD values of the editable alarm fields
    localparam logic [7:0] HR_MAX   = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/alarm_match_gen_if.sv
// Panel/time-of-day bus of the alarm match generator.
// The master side supplies the current time and the buttons; the slave side
// returns the stored alarm time, the edit hints and the bing strobe.
interface alarm_match_gen_if;

    logic [7:0] cur_hr;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       set_btn;
    logic       inc_btn;
    logic       alarm_en;
    logic [7:0] alm_hr;
    logic [7:0] alm_min;
    logic       edit_hr;
    logic       edit_min;
    logic       bing;

    modport master (
        output cur_hr, cur_min, cur_sec, set_btn, inc_btn, alarm_en,
        input  alm_hr, alm_min, edit_hr, edit_min, bing
    );

    modport slave (
        input  cur_hr, cur_min, cur_sec, set_btn, inc_btn, alarm_en,
        output alm_hr, alm_min, edit_hr, edit_min, bing
    );

endinterface

// File: rtl/bcd2_inc.sv
// Two-digit BCD incrementer that wraps to 00 after MAX.
// Passes the value through unchanged when en is low.
module bcd2_inc
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX = HR_MAX
) (
    input  logic       en,
    input  logic [7:0] val,
    output logic [7:0] nxt
);

    // Next BCD value: wrap at MAX, carry a low digit of 9 into the high digit
    always_comb begin
        nxt = val;
        if (en) begin
            if (val == MAX) begin
                nxt = BCD_ZERO;
            end else if (val[3:0] == 4'd9) begin
                nxt = {val[7:4] + 4'd1, 4'd0};
            end else begin
                nxt = {val[7:4], val[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/alarm_match_gen.sv
// Alarm time store, edit-mode FSM and match strobe generator.
// Produces one fixed-width bing pulse per rising edge of the time match
// while armed and in run mode.
module alarm_match_gen
    import alarm_pkg::*;
#(
    parameter logic [7:0]  ALM_HR_RST  = 8'h07,
    parameter logic [7:0]  ALM_MIN_RST = 8'h00,
    parameter int unsigned BING_CYCLES = 4
) (
    input  logic              clk,
    input  logic              CLR_n,
    alarm_match_gen_if.slave  bus
);

    state_t     state;
    state_t     state_nxt;
    logic       set_q;
    logic       inc_q;
    logic       set_rise;
    logic       inc_rise;
    logic [7:0] alm_hr_r;
    logic [7:0] alm_min_r;
    logic [7:0] hr_nxt;
    logic [7:0] min_nxt;
    logic       edit_hr_r;
    logic       edit_min_r;
    logic       match;
    logic       match_q;
    logic [7:0] bing_cnt;
    logic       bing_r;

    assign set_rise = bus.set_btn & ~set_q;
    assign inc_rise = bus.inc_btn & ~inc_q;

    bcd2_inc #(.MAX(HR_MAX)) u_hr_inc (
        .en  (inc_rise && (state == S_SET_HR)),
        .val (alm_hr_r),
        .nxt (hr_nxt)
    );

    bcd2_inc #(.MAX(MIN_MAX)) u_min_inc (
        .en  (inc_rise && (state == S_SET_MIN)),
        .val (alm_min_r),
        .nxt (min_nxt)
    );

    // Edit-mode sequencing: each set press advances run -> hour -> minute -> run
    always_comb begin
        state_nxt = state;
        if (set_rise) begin
            case (state)
                S_RUN:     state_nxt = S_SET_HR;
                S_SET_HR:  state_nxt = S_SET_MIN;
                S_SET_MIN: state_nxt = S_RUN;
                default:   state_nxt = S_RUN;
            endcase
        end
    end

    // Raw time match; only armed and in run mode can it fire
    always_comb begin
        match = (bus.cur_hr == alm_hr_r) && (bus.cur_min == alm_min_r) &&
                (bus.cur_sec == BCD_ZERO) && bus.alarm_en && (state == S_RUN);
    end

    // Button edge registers, alarm fields, FSM state and edit hints
    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            set_q      <= 1'b0;
            inc_q      <= 1'b0;
            state      <= S_RUN;
            alm_hr_r   <= ALM_HR_RST;
            alm_min_r  <= ALM_MIN_RST;
            edit_hr_r  <= 1'b0;
            edit_min_r <= 1'b0;
        end else begin
            set_q      <= bus.set_btn;
            inc_q      <= bus.inc_btn;
            state      <= state_nxt;
            alm_hr_r   <= hr_nxt;
            alm_min_r  <= min_nxt;
            edit_hr_r  <= (state_nxt == S_SET_HR);
            edit_min_r <= (state_nxt == S_SET_MIN);
        end
    end

    // Bing pulse: start on a match rising edge when idle, run BING_CYCLES clks
    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            match_q  <= 1'b0;
            bing_cnt <= 8'd0;
            bing_r   <= 1'b0;
        end else begin
            match_q <= match;
            if (bing_cnt != 8'd0) begin
                bing_cnt <= bing_cnt - 8'd1;
                bing_r   <= (bing_cnt > 8'd1);
            end else if (match && !match_q) begin
                bing_cnt <= 8'(BING_CYCLES);
                bing_r   <= 1'b1;
            end else begin
                bing_r   <= 1'b0;
            end
        end
    end

    assign bus.alm_hr   = alm_hr_r;
    assign bus.alm_min  = alm_min_r;
    assign bus.edit_hr  = edit_hr_r;
    assign bus.edit_min = edit_min_r;
    assign bus.bing     = bing_r;

endmodule

// File: tb/tb_alarm_match_gen.sv
// Directed bench for alarm_match_gen: reset, hour/minute editing with BCD
// carries and wraps, single-shot bing on match, and suppression cases.
module tb_alarm_match_gen;

    logic clk = 1'b0;
    logic CLR_n;

    always #5 clk = ~clk;

    alarm_match_gen_if bus ();

    alarm_match_gen #(
        .ALM_HR_RST  (8'h07),
        .ALM_MIN_RST (8'h00),
        .BING_CYCLES (4)
    ) dut (
        .clk   (clk),
        .CLR_n (CLR_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.cur_hr  = h;
        bus.cur_min = m;
        bus.cur_sec = s;
    endtask

    task automatic press_set();
        bus.set_btn = 1'b1;
        tick(1);
        bus.set_btn = 1'b0;
        tick(1);
    endtask

    task automatic press_inc();
        bus.inc_btn = 1'b1;
        tick(1);
        bus.inc_btn = 1'b0;
        tick(1);
    endtask

    // Wait (bounded) for bing; lat = negedges waited, or -1 if never seen
    task automatic wait_bing(output int lat);
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (bus.bing === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Count cycles with bing high over a window of n cycles
    task automatic count_bing(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.bing === 1'b1) cnt++;
            tick(1);
        end
    endtask

    logic [7:0] hr_exp [17] = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h00};

    initial begin
        int lat;
        int cnt;
        int e;
        logic [7:0] min_exp;

        CLR_n        = 1'b1;
        bus.set_btn  = 1'b0;
        bus.inc_btn  = 1'b0;
        bus.alarm_en = 1'b0;
        set_cur(8'h12, 8'h34, 8'h56);
        tick(3);
        check("rst_alm_hr", bus.alm_hr, 8'h07);
        check("rst_alm_min", bus.alm_min, 8'h00);
        check("rst_bing", {7'd0, bus.bing}, 8'h00);
        check("rst_edit_hr", {7'd0, bus.edit_hr}, 8'h00);
        check("rst_edit_min", {7'd0, bus.edit_min}, 8'h00);
        CLR_n = 1'b0;
        tick(2);

        // Hour editing: 17 presses from 07 walk through carries to 23 then 00
        press_set();
        check("hr_mode_edit_hr", {7'd0, bus.edit_hr}, 8'h01);
        check("hr_mode_edit_min", {7'd0, bus.edit_min}, 8'h00);
        for (int i = 0; i < 17; i++) begin
            press_inc();
            check("alm_hr_step", bus.alm_hr, hr_exp[i]);
        end

        // Minute editing: held button increments once, then wrap via 59
        press_set();
        check("min_mode_edit_min", {7'd0, bus.edit_min}, 8'h01);
        check("min_mode_edit_hr", {7'd0, bus.edit_hr}, 8'h00);
        bus.inc_btn = 1'b1;
        tick(20);
        bus.inc_btn = 1'b0;
        tick(1);
        check("alm_min_held", bus.alm_min, 8'h01);
        for (int i = 2; i <= 60; i++) begin
            press_inc();
            e = i % 60;
            min_exp = {4'(e / 10), 4'(e % 10)};
            check("alm_min_step", bus.alm_min, min_exp);
        end

        // Simultaneous set and inc in hour mode
        press_set();
        check("run_edit_hr", {7'd0, bus.edit_hr}, 8'h00);
        check("run_edit_min", {7'd0, bus.edit_min}, 8'h00);
        press_set();
        bus.set_btn = 1'b1;
        bus.inc_btn = 1'b1;
        tick(1);
        bus.set_btn = 1'b0;
        bus.inc_btn = 1'b0;
        tick(1);
        check("simul_alm_hr", bus.alm_hr, 8'h01);
        check("simul_edit_min", {7'd0, bus.edit_min}, 8'h01);
        check("simul_edit_hr", {7'd0, bus.edit_hr}, 8'h00);

        // Restore alarm to 07:00 and return to run mode
        press_set();
        press_set();
        for (int i = 0; i < 6; i++) press_inc();
        check("restore_alm_hr", bus.alm_hr, 8'h07);
        press_set();
        press_set();
        check("restore_alm_min", bus.alm_min, 8'h00);
        check("restore_edit_hr", {7'd0, bus.edit_hr}, 8'h00);

        // Match: single 4-cycle pulse, none during the rest of the held second
        set_cur(8'h06, 8'h59, 8'h59);
        bus.alarm_en = 1'b1;
        tick(3);
        check("pre_match_bing", {7'd0, bus.bing}, 8'h00);
        set_cur(8'h07, 8'h00, 8'h00);
        wait_bing(lat);
        check("match_latency_ok", {7'd0, (lat >= 1 && lat <= 2)}, 8'h01);
        count_bing(10, cnt);
        check("match_pulse_width", 8'(cnt), 8'd4);
        count_bing(90, cnt);
        check("match_no_repeat", 8'(cnt), 8'd0);

        // alarm_en dropping mid-pulse keeps the full width
        set_cur(8'h06, 8'h59, 8'h59);
        tick(2);
        set_cur(8'h07, 8'h00, 8'h00);
        wait_bing(lat);
        check("en_drop_started", {7'd0, (lat > 0)}, 8'h01);
        bus.alarm_en = 1'b0;
        count_bing(10, cnt);
        check("en_drop_width", 8'(cnt), 8'd4);

        // Disarmed: no pulse
        set_cur(8'h06, 8'h59, 8'h59);
        tick(2);
        set_cur(8'h07, 8'h00, 8'h00);
        count_bing(20, cnt);
        check("disarmed_bing", 8'(cnt), 8'd0);

        // In minute-edit mode: no pulse
        set_cur(8'h06, 8'h59, 8'h59);
        bus.alarm_en = 1'b1;
        press_set();
        press_set();
        check("supp_edit_min", {7'd0, bus.edit_min}, 8'h01);
        set_cur(8'h07, 8'h00, 8'h00);
        count_bing(20, cnt);
        check("edit_mode_bing", 8'(cnt), 8'd0);
        set_cur(8'h06, 8'h59, 8'h59);
        tick(1);
        press_set();
        check("back_run_edit_min", {7'd0, bus.edit_min}, 8'h00);

        // Seconds not zero: no pulse
        set_cur(8'h07, 8'h00, 8'h01);
        count_bing(20, cnt);
        check("sec_nonzero_bing", 8'(cnt), 8'd0);

        // Reset mid-pulse truncates bing at once
        set_cur(8'h06, 8'h59, 8'h59);
        tick(2);
        set_cur(8'h07, 8'h00, 8'h00);
        wait_bing(lat);
        check("rst_mid_started", {7'd0, (lat > 0)}, 8'h01);
        CLR_n = 1'b1;
        #1;
        check("rst_mid_bing", {7'd0, bus.bing}, 8'h00);
        check("rst_mid_alm_hr", bus.alm_hr, 8'h07);
        tick(2);
        set_cur(8'h12, 8'h00, 8'h00);
        CLR_n = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_match_gen.md
Name: alarm_match_gen

Overview:
- Upstream source of the `bing` strobe consumed by the alarm-LED blinker stage.
- Holds a user-settable alarm time (HH:MM, BCD) edited with panel buttons.
- Compares the alarm time against the running clock's current time.
- Emits a bounded-width `bing` pulse once per match while armed.
- Sits between the time-of-day counter/button conditioning logic and the LED/buzzer alarm stage.

Parameters:
- ALM_HR_RST, 8'h07, BCD alarm hour loaded on reset
- ALM_MIN_RST, 8'h00, BCD alarm minute loaded on reset
- BING_CYCLES, 4, width of `bing` pulse in clk cycles (1..255)

Ports:
- clk  in  1  system clock; all state rises on posedge
- CLR_n  in  1  reset, asynchronous, active-high
- cur_hr  in  8  current hour, BCD 00..23
- cur_min  in  8  current minute, BCD 00..59
- cur_sec  in  8  current second, BCD 00..59
- set_btn  in  1  debounced level, clk-synchronous; rising edge cycles the edit mode
- inc_btn  in  1  debounced level, clk-synchronous; rising edge increments the selected field
- alarm_en  in  1  level; 1 = alarm armed
- alm_hr  out  8  stored alarm hour, BCD
- alm_min  out  8  stored alarm minute, BCD
- edit_hr  out  1  1 while in S_SET_HR (display blink hint)
- edit_min  out  1  1 while in S_SET_MIN
- bing  out  1  alarm strobe, high for BING_CYCLES clks

Behaviour:
- Reset (CLR_n=1, any time, async):
  - alm_hr=ALM_HR_RST, alm_min=ALM_MIN_RST.
  - state=S_RUN; bing=0; edit_hr=edit_min=0.
  - Pulse counter=0; match_q=0; button edge registers=0.
  - A reset mid-pulse truncates bing immediately.
- Edge detect: set_rise = set_btn & ~set_q; inc_rise = inc_btn & ~inc_q. One registered delay, so the action lands on the clk after the first high sample.
- FSM transitions:
  - S_RUN -set_rise-> S_SET_HR
  - S_SET_HR -set_rise-> S_SET_MIN
  - S_SET_MIN -set_rise-> S_RUN
- inc_rise handling:
  - In S_SET_HR: alm_hr +1 in BCD, 23 wraps to 00.
  - In S_SET_MIN: alm_min +1 in BCD, 59 wraps to 00.
  - In S_RUN: ignored.
  - Low-digit 9 carries to the high digit (09->10, 19->20).
  - A held button increments once only.
- Simultaneous set_rise and inc_rise: the increment applies to the current field first, then the state advances.
- Match:
  - match = (cur_hr==alm_hr) & (cur_min==alm_min) & (cur_sec==8'h00) & alarm_en & (state==S_RUN).
  - match_q registers match each clk.
- Bing:
  - On match & ~match_q (rising edge) with the pulse counter idle: bing=1 next clk, held exactly BING_CYCLES clks, then 0.
  - A match rising edge during an active pulse is ignored; the pulse is not restarted.
  - Match held across the whole second fires once only.
  - alarm_en dropping mid-pulse does not cut the pulse.
  - Entering set mode suppresses new matches only.
- Invalid BCD on cur_* inputs: plain equality compare, no correction. Stored alm_* never leave the legal range.
- Outputs alm_hr, alm_min, edit_hr, edit_min, bing are all registered.

Decomposition:
- Package alarm_pkg:
  - State enum S_RUN/S_SET_HR/S_SET_MIN (2-bit).
  - BCD limit constants HR_MAX=8'h23, MIN_MAX=8'h59.
  - Zero constant BCD_ZERO=8'h00.
- Sub-module bcd2_inc:
  - Parameter MAX.
  - Inputs: en, 8-bit value. Output: next value, wrapping to 00 after MAX.
  - Combinational, instantiated twice.
- FSM, edge detect, match and pulse counter stay in the top module.

Test Plan:
- Reset: CLR_n=1 for 3 clks -> alm_hr=07, alm_min=00, bing=0, edit_hr=edit_min=0; assert CLR_n mid-pulse -> bing=0 same cycle.
- Set hour:
  - Stimulus: set_btn pulse, then inc_btn pulsed 17 times from 07.
  - Required: edit_hr=1, alm_hr=24 invalid never seen; sequence ends 23->00 after one more pulse, with 09->10 and 19->20 carries correct.
- Set minute: two set_btn pulses, inc_btn held high 20 clks -> alm_min 00->01 only; 60 pulses return alm_min to 00 via 59->00.
- Match:
  - Stimulus: alarm 07:00, alarm_en=1, cur steps 06:59:59 -> 07:00:00, cur held for 100 clks.
  - Required: bing high exactly 4 clks starting 2 clks after cur change; no second pulse during the held second.
- Suppression: same match with alarm_en=0, or with state=S_SET_MIN -> bing stays 0; cur 07:00:01 with alarm_en=1 -> bing stays 0.
- Simultaneous: set_rise and inc_rise on same clk in S_SET_HR -> alm_hr increments and state becomes S_SET_MIN.
